multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for a multicycle RV32I-subset datapath (lw, sw, R-type,
//   I-type ALU, beq, jal). Every instruction passes through FETCH and DECODE,
//   then through a short class-specific sequence of states. Undecodable
//   opcodes lock the FSM in TRAP until reset. A counter tracks retired
//   instructions.
//
// Memory handshake: the controller presents an access in FETCH, MEMREAD or
//   MEMWRITE and holds it (address select, mem_write) for as long as
//   mem_ready is low. The access completes in the cycle where mem_ready is
//   high; only then does the FSM move on. With MEM_WAIT=0 mem_ready is
//   ignored and every access completes in one cycle.
//
// Parameters:
//   MEM_WAIT  - 1: honour mem_ready, 0: treat mem_ready as always 1
//   CNT_WIDTH - width of the retired-instruction counter
// Ports:
//   clk, rst         - clock (rising edge), asynchronous active-high reset
//   op               - instr[6:0] from the instruction register
//   zero             - ALU zero flag (branch condition)
//   mem_ready        - memory access completes this cycle
//   pc_write, ir_write, adr_src, mem_write, reg_write - 1-bit controls
//   result_src, alu_src_a, alu_src_b, alu_op, imm_src - 2-bit controls
//   trap             - illegal-opcode flag
//   state            - current FSM state (debug/observability)
//   retired          - count of completed instructions (wraps)
module multicycle_controller #(
  parameter int MEM_WAIT  = 1,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           imm_src,
  output logic                 trap,
  output logic [3:0]           state,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd15;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [3:0]           state_q;
  logic [3:0]           state_d;
  logic [CNT_WIDTH-1:0] retired_q;
  logic                 mem_ok;
  logic                 pc_update;
  logic                 branch;
  logic                 retire_evt;

  assign mem_ok  = (MEM_WAIT == 0) ? 1'b1 : mem_ready;
  assign state   = state_q;
  assign retired = retired_q;

  // Branch target is taken only when the ALU compare reports equality.
  assign pc_write = pc_update | (branch & zero);

  // Immediate format depends only on the opcode, not on the state.
  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    trap       = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ok) begin
          ir_write  = 1'b1;
          pc_update = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ok) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        // mem_write stays asserted until the memory accepts the store.
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ok) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_TRAP: begin
        trap    = 1'b1;
        state_d = S_TRAP;
      end
      // Unused encodings are treated as corruption and fall into TRAP.
      default: state_d = S_TRAP;
    endcase
  end

  // An instruction retires when its final state hands back to FETCH.
  assign retire_evt = (state_d == S_FETCH) &&
                      ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                       (state_q == S_ALUWB) || (state_q == S_BEQ));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire_evt) retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//   Two controllers run side by side: dut_a (MEM_WAIT=1, 4-bit counter) and
//   dut_b (MEM_WAIT=0, 8-bit counter). Each is compared every cycle against
//   an instruction-level model: an instruction is a fixed path of states
//   chosen by its opcode class, memory states repeat while mem_ready is low,
//   and finishing a path retires one instruction.
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [6:0] op_a = OP_LW;
  logic [6:0] op_b = OP_LW;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic       a_pc_write, a_ir_write, a_adr_src, a_mem_write, a_reg_write, a_trap;
  logic [1:0] a_result_src, a_alu_src_a, a_alu_src_b, a_alu_op, a_imm_src;
  logic [3:0] a_state;
  logic [3:0] a_retired;
  logic       b_pc_write, b_ir_write, b_adr_src, b_mem_write, b_reg_write, b_trap;
  logic [1:0] b_result_src, b_alu_src_a, b_alu_src_b, b_alu_op, b_imm_src;
  logic [3:0] b_state;
  logic [7:0] b_retired;

  multicycle_controller #(.MEM_WAIT(1), .CNT_WIDTH(4)) dut_a (
    .clk(clk), .rst(rst), .op(op_a), .zero(zero), .mem_ready(mem_ready),
    .pc_write(a_pc_write), .ir_write(a_ir_write), .adr_src(a_adr_src),
    .mem_write(a_mem_write), .reg_write(a_reg_write),
    .result_src(a_result_src), .alu_src_a(a_alu_src_a),
    .alu_src_b(a_alu_src_b), .alu_op(a_alu_op), .imm_src(a_imm_src),
    .trap(a_trap), .state(a_state), .retired(a_retired)
  );

  multicycle_controller #(.MEM_WAIT(0), .CNT_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .op(op_b), .zero(zero), .mem_ready(mem_ready),
    .pc_write(b_pc_write), .ir_write(b_ir_write), .adr_src(b_adr_src),
    .mem_write(b_mem_write), .reg_write(b_reg_write),
    .result_src(b_result_src), .alu_src_a(b_alu_src_a),
    .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .imm_src(b_imm_src),
    .trap(b_trap), .state(b_state), .retired(b_retired)
  );

  logic [19:0] obs_a, obs_b;
  assign obs_a = {a_pc_write, a_ir_write, a_adr_src, a_mem_write, a_reg_write,
                  a_result_src, a_alu_src_a, a_alu_src_b, a_alu_op, a_imm_src,
                  a_trap, a_state};
  assign obs_b = {b_pc_write, b_ir_write, b_adr_src, b_mem_write, b_reg_write,
                  b_result_src, b_alu_src_a, b_alu_src_b, b_alu_op, b_imm_src,
                  b_trap, b_state};

  // ---------------- reference model ----------------
  int vectors = 0;
  int miscompares = 0;

  // Instruction paths by class: lw, sw, R, I, beq, jal, illegal.
  int path_tab [0:6][0:4] = '{'{0, 1, 2, 3, 4}, '{0, 1, 2, 5, 0},
                              '{0, 1, 6, 8, 0}, '{0, 1, 7, 8, 0},
                              '{0, 1, 9, 0, 0}, '{0, 1, 10, 8, 0},
                              '{0, 1, 15, 0, 0}};
  int path_len [0:6] = '{5, 4, 4, 4, 3, 4, 3};

  int cur [2];
  int pidx [2];
  int ret [2];
  bit need_op [2];
  bit auto_a = 1'b0;

  function automatic int op_class(logic [6:0] o);
    case (o)
      OP_LW:   return 0;
      OP_SW:   return 1;
      OP_R:    return 2;
      OP_I:    return 3;
      OP_BEQ:  return 4;
      OP_JAL:  return 5;
      default: return 6;
    endcase
  endfunction

  function automatic logic [6:0] rand_legal_op();
    case ($urandom_range(0, 5))
      0:       return OP_LW;
      1:       return OP_SW;
      2:       return OP_R;
      3:       return OP_I;
      4:       return OP_BEQ;
      default: return OP_JAL;
    endcase
  endfunction

  // Control word a state should present, straight from the state table.
  function automatic logic [19:0] exp_vec(int st, logic [6:0] o, logic z, logic mr);
    logic pcu, br, irw, adr, mw, rw, tr;
    logic [1:0] res, sa, sb, aop, imm;
    {pcu, br, irw, adr, mw, rw, tr} = '0;
    {res, sa, sb, aop} = '0;
    imm = (o == OP_SW) ? 2'b01 : (o == OP_BEQ) ? 2'b10 : (o == OP_JAL) ? 2'b11 : 2'b00;
    case (st)
      0:  begin sb = 2'b10; res = 2'b10; irw = mr; pcu = mr; end
      1:  begin sa = 2'b01; sb = 2'b01; end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  adr = 1'b1;
      4:  begin res = 2'b01; rw = 1'b1; end
      5:  begin adr = 1'b1; mw = 1'b1; end
      6:  begin sa = 2'b10; aop = 2'b10; end
      7:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      8:  rw = 1'b1;
      9:  begin sa = 2'b10; aop = 2'b01; br = 1'b1; end
      10: begin sa = 2'b01; sb = 2'b10; pcu = 1'b1; end
      15: tr = 1'b1;
      default: ;
    endcase
    return {pcu | (br & z), irw, adr, mw, rw, res, sa, sb, aop, imm, tr, 4'(st)};
  endfunction

  task automatic advance(int d, logic mr);
    int cls;
    cls = op_class(d == 0 ? op_a : op_b);
    if (cur[d] == 15) return;
    if ((cur[d] == 0 || cur[d] == 3 || cur[d] == 5) && !mr) return;
    pidx[d]++;
    if (pidx[d] == path_len[cls]) begin
      cur[d] = 0;
      pidx[d] = 0;
      ret[d] = (ret[d] + 1) % ((d == 0) ? 16 : 256);
      need_op[d] = 1'b1;
    end else begin
      cur[d] = path_tab[cls][pidx[d]];
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(int d);
    logic [19:0] e;
    if (d == 0) begin
      e = exp_vec(cur[0], op_a, zero, mem_ready);
      vectors++;
      assert (obs_a === e) else begin
        miscompares++;
        $error("FAIL ctrl_a st=%0d observed=%h expected=%h", cur[0], obs_a, e);
      end
      check_val("retired_a", 32'(a_retired), 32'(ret[0]));
    end else begin
      e = exp_vec(cur[1], op_b, zero, 1'b1);
      vectors++;
      assert (obs_b === e) else begin
        miscompares++;
        $error("FAIL ctrl_b st=%0d observed=%h expected=%h", cur[1], obs_b, e);
      end
      check_val("retired_b", 32'(b_retired), 32'(ret[1]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pick_ops();
    if (need_op[1]) begin op_b = rand_legal_op(); need_op[1] = 1'b0; end
    if (need_op[0] && auto_a) begin op_a = rand_legal_op(); need_op[0] = 1'b0; end
  endtask

  // One clock: check outputs at the falling edge, then follow the rising edge.
  task automatic step();
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    #1;
    advance(0, mem_ready);
    advance(1, 1'b1);
    pick_ops();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cur[d] = 0; pidx[d] = 0; ret[d] = 0; need_op[d] = 1'b1;
    end
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pick_ops();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int saved;
    reset_dut();

    // lw with an always-ready memory: 0,1,2,3,4 then back to FETCH
    op_a = OP_LW; mem_ready = 1'b1;
    repeat (5) step();
    check_val("lw_state", 32'(a_state), 32'd0);
    check_val("lw_retired", 32'(a_retired), 32'd1);

    // beq taken then not taken; both retire
    op_a = OP_BEQ; zero = 1'b1;
    repeat (3) step();
    op_a = OP_BEQ; zero = 1'b0;
    repeat (3) step();
    check_val("beq_retired", 32'(a_retired), 32'd3);

    // sw with the store held off for three cycles
    op_a = OP_SW; mem_ready = 1'b1;
    repeat (3) step();
    check_val("sw_in_memwrite", 32'(a_state), 32'd5);
    mem_ready = 1'b0;
    repeat (3) step();
    mem_ready = 1'b1;
    step();
    check_val("sw_state", 32'(a_state), 32'd0);
    check_val("sw_retired", 32'(a_retired), 32'd4);

    // illegal opcode locks into TRAP until reset
    op_a = 7'b0000000;
    repeat (2) step();
    check_val("trap_entry", 32'(a_trap), 32'd1);
    repeat (10) step();
    check_val("trap_held", 32'(a_state), 32'd15);
    reset_dut();
    check_val("trap_cleared", 32'(a_trap), 32'd0);

    // 16 R-type instructions wrap the 4-bit counter back to 0
    op_a = OP_R; mem_ready = 1'b1;
    repeat (64) step();
    check_val("wrap_retired", 32'(a_retired), 32'd0);
    check_val("wrap_state", 32'(a_state), 32'd0);

    // reset between clock edges while waiting in MEMREAD
    reset_dut();
    op_a = OP_LW; mem_ready = 1'b1;
    repeat (3) step();
    mem_ready = 1'b0;
    step();
    check_val("pre_abort_state", 32'(a_state), 32'd3);
    saved = ret[0];
    #2;
    rst = 1'b1;
    #1;
    check_val("abort_state_a", 32'(a_state), 32'd0);
    check_val("abort_state_b", 32'(b_state), 32'd0);
    check_val("abort_retired", 32'(a_retired), 32'(saved));
    reset_dut();

    // randomized instruction stream with random memory stalls
    auto_a = 1'b1;
    need_op[0] = 1'b1;
    pick_ops();
    repeat (600) begin
      mem_ready = ($urandom_range(0, 3) != 0);
      zero = 1'($urandom_range(0, 1));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
